// File: rtl/pmt_pkg.sv
// Shared types and helpers for the click-stage permit scheduler.
package pmt_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_FIRE,
        DONE
    } state_t;

    // First set requester at or after ptr, wrapping at nreq; returns ptr when none is set.
    function automatic logic [2:0] rr_pick(input logic [7:0] req_vec, input logic [2:0] ptr,
                                           input int nreq);
        logic [2:0] pick;
        logic       found;
        int         c;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c = (int'(ptr) + k) % nreq;
            if (!found && (k < nreq) && req_vec[c[2:0]]) begin
                pick  = c[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pmt_issue_sched_evt_sync.sv
// Synchroniser plus toggle detector: one registered pulse per transition on async_in.
module pmt_evt_sync
    import pmt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   evt_q, evt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d = sync_q[SYNC_STAGES-1];
        evt_d  = sync_q[SYNC_STAGES-1] ^ hist_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            evt_q  <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/pmt_issue_sched.sv
// Round-robin issue of tokens into a shared click permit stage, with credit tracking.
// Optional watchdog on WAIT_FIRE enabled by defining PMT_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for a request, free credit and hold low
// GRANT     | gnt/drive/pmt just issued for the picked requester
// WAIT_FIRE | token in the stage, waiting for the relay fire event
// DONE      | done pulse to the requester, round-robin pointer advanced
module pmt_issue_sched
    import pmt_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int CREDITS     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             drive,
    output logic             pmt,
    input  logic             fire,
    input  logic             free,
    input  logic             hold,
    output logic [CNT_W-1:0] inflight,
    output logic             err
);

    if (NREQ < 2 || NREQ > 8 || CREDITS < 1 || CREDITS > 7 || TO_CYCLES < 1) begin : g_bad_param
        $error("pmt_issue_sched: parameter out of range");
    end

    localparam logic [CNT_W-1:0] CRED     = CNT_W'(CREDITS);
    localparam logic [2:0]       LAST_IDX = 3'(NREQ - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
    logic              drive_q, drive_d, pmt_q, pmt_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d, idx_q, idx_d, pick;
    logic [7:0]        req_ext;
    logic              fire_evt, free_evt, grant_inc, free_dec, to_clr;

    pmt_evt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fire_sync (
        .clk(clk), .rst(rst), .async_in(fire), .evt(fire_evt)
    );
    pmt_evt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_free_sync (
        .clk(clk), .rst(rst), .async_in(free), .evt(free_evt)
    );

`ifdef PMT_TIMEOUT_EN
    localparam int               TO_W    = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        drive_d    = drive_q;
        pmt_d      = pmt_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        grant_inc  = 1'b0;
        to_clr     = 1'b0;
        req_ext    = '0;
        req_ext[NREQ-1:0] = req;
        pick       = rr_pick(req_ext, rr_ptr_q, NREQ);
        free_dec   = free_evt && (inflight_q != '0);
`ifdef PMT_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (hold) pmt_d = 1'b0;
                if (!hold && (|req) && (inflight_q < CRED)) begin
                    idx_d = pick;
                    for (int i = 0; i < NREQ; i++) gnt_d[i] = (pick == i[2:0]);
                    drive_d   = ~drive_q;
                    pmt_d     = 1'b1;
                    grant_inc = 1'b1;
                    state_d   = GRANT;
`ifdef PMT_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end
            GRANT: state_d = WAIT_FIRE;
            WAIT_FIRE: begin
                if (fire_evt) begin
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    rr_ptr_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                    pmt_d    = pmt_q & ~hold;
                    state_d  = DONE;
                end
`ifdef PMT_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    pmt_d   = 1'b0;
                    gnt_d   = '0;
                    to_clr  = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A grant and a free in the same cycle cancel out.
        inflight_d = inflight_q;
        if (to_clr)                      inflight_d = '0;
        else if (grant_inc && !free_dec) inflight_d = inflight_q + 1'b1;
        else if (!grant_inc && free_dec) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            drive_q    <= 1'b0;
            pmt_q      <= 1'b0;
            inflight_q <= '0;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
`ifdef PMT_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            drive_q    <= drive_d;
            pmt_q      <= pmt_d;
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
`ifdef PMT_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign drive    = drive_q;
    assign pmt      = pmt_q;
    assign inflight = inflight_q;
`ifdef PMT_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: doc/pmt_issue_sched.md
# pmt_issue_sched

Synchronous scheduler that shares one click-pipeline permit stage (sender → permit relay → receiver) among several clocked requesters. It arbitrates round-robin, issues one token per grant as a transition on the stage's drive input, holds the relay permit `pmt`, and confirms completion by synchronising the relay's fire and free transitions back into the clock domain. It sits on the boundary between the clocked control logic and the self-timed click FIFO.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CREDITS`, 2, maximum tokens in flight inside the click stage (1..7)
- `SYNC_STAGES`, 2, flip-flops per asynchronous input synchroniser (2..3)
- `TO_CYCLES`, 255, watchdog limit in clocks (used only with `PMT_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  level request per requester; held until `done` is seen
- `gnt`  out  NREQ  one-hot grant; reset 0
- `done`  out  NREQ  one-cycle pulse to the granted requester when its token has fired; reset 0
- `drive`  out  1  transition-signalled token launch to the sender; reset 0
- `pmt`  out  1  permit level to the relay; reset 0
- `fire`  in  1  relay fire, transition-signalled, asynchronous
- `free`  in  1  sender free, transition-signalled, asynchronous
- `hold`  in  1  synchronous level; while 1, no new grant is issued and `pmt` drops after the current token
- `inflight`  out  3  current credit count; reset 0
- `err`  out  1  sticky watchdog flag; reset 0 (tied 0 without the macro)

## Operation
- `fire` and `free` each pass through a `SYNC_STAGES` synchroniser and an edge detector; each detected toggle is one event.
- States: IDLE → GRANT → WAIT_FIRE → DONE → IDLE.
- IDLE: if `hold`=0, any `req` set, and `inflight` < `CREDITS`, pick the first set requester at or after `rr_ptr` (wrap from NREQ-1 to 0) and go to GRANT.
- GRANT (one cycle): set `gnt` one-hot, toggle `drive`, set `pmt`=1, and increment `inflight`. Go to WAIT_FIRE.
- WAIT_FIRE: on a fire event go to DONE. `gnt` and `pmt` are held.
- DONE (one cycle): pulse `done[i]`, clear `gnt`, set `rr_ptr`=i+1 mod NREQ. `pmt` stays 1 unless `hold`=1. Return to IDLE.
- A free event decrements `inflight`, in any state.
- Simultaneous free event and GRANT increment: `inflight` is unchanged.
- A free event when `inflight`=0 is ignored, and `inflight` saturates at 0.
- A fire event outside WAIT_FIRE is dropped.
- `req` deasserted during WAIT_FIRE: the token still completes and `done` still pulses.
- Reset mid-operation: all outputs return to their reset values. `drive` returning to 0 can itself be a transition; the click stage must be reset together with this block.

## Timing
- Grant latency: 1 clock from `req` sampled in IDLE to `gnt`/`drive`.
- Completion latency: the fire event is detected `SYNC_STAGES`+1 clocks after the `fire` toggle, and `done` pulses 1 clock later.
- Back-to-back issue: minimum 4 clocks per token plus synchroniser latency.
- All outputs are registered.

## Configuration
- `PMT_TIMEOUT_EN` defined:
  - A counter runs in WAIT_FIRE.
  - When it reaches `TO_CYCLES`, `err` sets (sticky until reset), `pmt` clears, `gnt` clears, no `done` is pulsed, `inflight` is cleared, and the FSM returns to IDLE.
- `PMT_TIMEOUT_EN` undefined: no counter, `err`=0, and WAIT_FIRE waits indefinitely.

## Structure
- Shared package `pmt_pkg`: state enum (IDLE, GRANT, WAIT_FIRE, DONE), `CNT_W`=3, and the round-robin pick function.
- One sub-module, `pmt_evt_sync`: a `SYNC_STAGES` synchroniser plus toggle detector producing a 1-clock event pulse. It is instantiated twice, for `fire` and `free`.

## Test plan
- Reset: with `rst`=0, all outputs are 0; after release with `req`=0, the FSM stays in IDLE and `drive` never toggles.
- Single request: `req`=0001, fire toggled 3 clocks after `drive` → `gnt`=0001, `done[0]` pulses once, `inflight`=1 until the free toggle, then 0.
- Round-robin: `req`=1011 held, each fire answered → grant order 0,1,3,0. With `rr_ptr` at 3, wrap-around grants 3 then 0.
- Credit limit: `CREDITS`=2, free withheld → two grants, then IDLE stalls with `inflight`=2. One free toggle → the next grant follows within 1 clock.
- Simultaneous events: free event in the same cycle as GRANT with `inflight`=1 → `inflight` stays 1. Spurious fire in IDLE → no `done`.
- `PMT_TIMEOUT_EN` with `TO_CYCLES`=16: fire never toggles → after 16 clocks in WAIT_FIRE, `err`=1, `pmt`=0, `gnt`=0, no `done`. The next `req` is still granted.
